wb_mem_arbiter: RTL

//  Shares one physical-memory Wishbone port between the pipeline's ifetch and data (MEM stage) masters.
//  Two slave-side ports (i_*, d_*), one master-side port (m_*), 128-bit line transfers on line addresses.

---
 rtl/wb_mem_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: shares one line-wide Wishbone memory port between the
// ifetch (i_*) and data (d_*) masters, with a per-transfer ACK watchdog.
// Optional build macro ARB_ROUND_ROBIN_EN: simultaneous requests alternate
// between the two masters. Without it, the data master always wins a tie.
module wb_mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 128,
  parameter int SEL_W   = 16,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  // ifetch master
  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic [ADDR_W-1:0] i_adr,
  output logic [DATA_W-1:0] i_dat_s,
  output logic              i_ack,
  // data master
  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [SEL_W-1:0]  d_sel,
  input  logic [DATA_W-1:0] d_dat_m,
  output logic [DATA_W-1:0] d_dat_s,
  output logic              d_ack,
  // shared memory port
  output logic              m_cyc,
  output logic              m_stb,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_adr,
  output logic [SEL_W-1:0]  m_sel,
  output logic [DATA_W-1:0] m_dat_m,
  input  logic [DATA_W-1:0] m_dat_s,
  input  logic              m_ack,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  typedef enum logic {OWNER_I, OWNER_D} owner_t;

  // A zero TIMEOUT disables the watchdog; the compare value is then unused.
  localparam logic             WDOG_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WDOG_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t           state, state_next;
  owner_t           last_gnt, last_gnt_next;
  logic [CNT_W-1:0] wdog;
  logic             i_req, d_req;
  logic             d_wins_tie;
  logic             wdog_expire;
  logic             timeout_hit;

  assign i_req = i_cyc & i_stb;
  assign d_req = d_cyc & d_stb;

  // Read data is shared; only the routed ack tells a master the data is for it.
  assign i_dat_s = m_dat_s;
  assign d_dat_s = m_dat_s;

  assign wdog_expire = WDOG_EN && (wdog == WDOG_LAST);

`ifdef ARB_ROUND_ROBIN_EN
  assign d_wins_tie = (last_gnt == OWNER_I);
`else
  assign d_wins_tie = 1'b1;
`endif

  // State register, watchdog counter, last-grant memory and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_gnt    <= OWNER_I;
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_next;
      last_gnt <= last_gnt_next;
      if (state != IDLE && state_next == state) begin
        wdog <= wdog + 1'b1;
      end else begin
        wdog <= '0;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // Arbitration, memory-port muxing, ack routing and transfer termination.
  always_comb begin
    state_next    = state;
    last_gnt_next = last_gnt;
    timeout_hit   = 1'b0;
    m_cyc         = 1'b0;
    m_stb         = 1'b0;
    m_we          = 1'b0;
    m_adr         = '0;
    m_sel         = '0;
    m_dat_m       = '0;
    i_ack         = 1'b0;
    d_ack         = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!i_req || d_wins_tie)) begin
          state_next = GNT_D;
        end else if (i_req) begin
          state_next = GNT_I;
        end
      end
      GNT_I: begin
        m_cyc = i_cyc;
        m_stb = i_stb;
        m_adr = i_adr;
        m_sel = {SEL_W{1'b1}};
        i_ack = m_ack;
        if (m_ack) begin
          state_next    = IDLE;
          last_gnt_next = OWNER_I;
        end else if (!i_cyc) begin
          state_next = IDLE;
        end else if (wdog_expire) begin
          state_next    = IDLE;
          last_gnt_next = OWNER_I;
          timeout_hit   = 1'b1;
        end
      end
      GNT_D: begin
        m_cyc   = d_cyc;
        m_stb   = d_stb;
        m_we    = d_we;
        m_adr   = d_adr;
        m_sel   = d_sel;
        m_dat_m = d_dat_m;
        d_ack   = m_ack;
        if (m_ack) begin
          state_next    = IDLE;
          last_gnt_next = OWNER_D;
        end else if (!d_cyc) begin
          state_next = IDLE;
        end else if (wdog_expire) begin
          state_next    = IDLE;
          last_gnt_next = OWNER_D;
          timeout_hit   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
